// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings and LCD command bytes for the phrase driver
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      IDLE,
      SET_ADDR,
      WRITE_CHAR,
      CLR_WAIT
   } lcd_state_e;

   // PH_START only occurs between IDLE and the first SETUP of a refresh.
   typedef enum logic [1:0] {
      PH_START,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } lcd_phase_e;

   localparam logic [7:0] CMD_FUNC_1L = 8'h30;
   localparam logic [7:0] CMD_FUNC_2L = 8'h38;
   localparam logic [7:0] CMD_DISP_ON = 8'h0C;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_ROW0    = 8'h80;
   localparam logic [7:0] CMD_ROW1    = 8'hC0;

   localparam int PWR_WAIT_TICKS = 20;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx, input logic two_rows);
      logic [7:0] cmd;
      unique case (idx)
         2'd0:    cmd = two_rows ? CMD_FUNC_2L : CMD_FUNC_1L;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_ENTRY;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - one-clock tick every DIV clocks, counter 0..DIV-1
module lcd_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clock50MHz,
   input  logic reset,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clock50MHz or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lcd_phrase_driver.sv
// rtl/lcd_phrase_driver.sv - HD44780-style driver: power wait, init, then full-screen refresh per request
module lcd_phrase_driver
   import lcd_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 500,
   parameter int COLS    = 16,
   parameter int ROWS    = 2,
   localparam int ADDR_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic              clock50MHz,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        char_data,
   output logic [ADDR_W-1:0] char_addr,
   output logic              busy,
   output logic              RS,
   output logic              RW,
   output logic              E,
   output logic [7:0]        DB
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int COL_W = 6;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic LAST_ROW = 1'(ROWS - 1);
   localparam logic TWO_ROWS = (ROWS == 2);

   logic tick;

   lcd_state_e        state_q, state_d;
   lcd_phase_e        phase_q, phase_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              rs_q, rs_d;
   logic              e_q, e_d;
   logic [7:0]        db_q, db_d;
   logic              load_char;

   lcd_tick_gen #(.DIV(DIV)) u_tick (
      .clock50MHz (clock50MHz),
      .reset      (reset),
      .tick       (tick)
   );

   // Every write is SETUP -> STROBE -> HOLD; the tick that ends HOLD loads the next SETUP.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      addr_d    = addr_q;
      pend_d    = pend_q;
      busy_d    = busy_q;
      rs_d      = rs_q;
      e_d       = e_q;
      db_d      = db_q;
      load_char = 1'b0;

      if (start && state_q != IDLE) pend_d = 1'b1;

      if (state_q == IDLE) begin
         if (start || pend_q) begin
            state_d = SET_ADDR;
            phase_d = PH_START;
            busy_d  = 1'b1;
            pend_d  = 1'b0;
            row_d   = 1'b0;
            col_d   = '0;
            addr_d  = '0;
         end
      end else if (tick) begin
         unique case (state_q)
            PWR_WAIT: begin
               if (cnt_q == 5'(PWR_WAIT_TICKS - 1)) begin
                  state_d = INIT;
                  phase_d = PH_SETUP;
                  cnt_d   = '0;
                  rs_d    = 1'b0;
                  db_d    = init_cmd(2'd0, TWO_ROWS);
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            CLR_WAIT: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               unique case (phase_q)
                  PH_SETUP: begin
                     e_d     = 1'b1;
                     phase_d = PH_STROBE;
                  end
                  PH_STROBE: begin
                     e_d     = 1'b0;
                     phase_d = PH_HOLD;
                  end
                  default: begin
                     phase_d = PH_SETUP;
                     unique case (state_q)
                        INIT: begin
                           if (cnt_q == 5'd3) begin
                              state_d = CLR_WAIT;
                           end else begin
                              cnt_d = cnt_q + 5'd1;
                              rs_d  = 1'b0;
                              db_d  = init_cmd(cnt_q[1:0] + 2'd1, TWO_ROWS);
                           end
                        end
                        SET_ADDR: begin
                           if (phase_q == PH_START) begin
                              rs_d = 1'b0;
                              db_d = row_q ? CMD_ROW1 : CMD_ROW0;
                           end else begin
                              state_d   = WRITE_CHAR;
                              load_char = 1'b1;
                           end
                        end
                        default: begin
                           if (col_q == LAST_COL) begin
                              if (row_q == LAST_ROW) begin
                                 state_d = IDLE;
                                 busy_d  = 1'b0;
                              end else begin
                                 state_d = SET_ADDR;
                                 row_d   = 1'b1;
                                 col_d   = '0;
                                 rs_d    = 1'b0;
                                 db_d    = CMD_ROW1;
                              end
                           end else begin
                              col_d     = col_q + COL_W'(1);
                              load_char = 1'b1;
                           end
                        end
                     endcase
                  end
               endcase
            end
         endcase
      end

      // char_addr moves to the next index as soon as the current byte is captured.
      if (load_char) begin
         rs_d   = 1'b1;
         db_d   = char_data;
         addr_d = (col_d == LAST_COL && row_d == LAST_ROW) ? '0 : addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock50MHz or negedge reset) begin
      if (!reset) begin
         state_q <= PWR_WAIT;
         phase_q <= PH_SETUP;
         cnt_q   <= '0;
         row_q   <= 1'b0;
         col_q   <= '0;
         addr_q  <= '0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b1;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         db_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         db_q    <= db_d;
      end
   end

   assign char_addr = addr_q;
   assign busy      = busy_q;
   assign RS        = rs_q;
   assign RW        = 1'b0;
   assign E         = e_q;
   assign DB        = db_q;

endmodule

// File: tb/tb_lcd_phrase_driver.sv
// tb/tb_lcd_phrase_driver.sv - self-checking bench for a 16x2 and an 8x1 phrase driver
module tb_lcd_phrase_driver;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 500;
   localparam int D       = CLK_HZ / TICK_HZ;
   localparam int COLS_A  = 16;
   localparam int ROWS_A  = 2;
   localparam int COLS_B  = 8;
   localparam int ROWS_B  = 1;
   localparam int N_A     = COLS_A * ROWS_A;
   localparam int N_B     = COLS_B * ROWS_B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, start_a, start_b;
   logic [7:0] cd_a, cd_b, db_a, db_b;
   logic [4:0] addr_a;
   logic [2:0] addr_b;
   logic       busy_a, busy_b, rs_a, rs_b, rw_a, rw_b, e_a, e_b;

   logic [7:0] bank_a [N_A];
   logic [7:0] bank_b [N_B];

   int checks = 0;
   int errors = 0;

   logic [8:0] wq_a [$];
   logic [8:0] wq_b [$];
   logic [8:0] exp_q [$];
   int         busy_clk_a = 0;

   lcd_phrase_driver #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .COLS(COLS_A), .ROWS(ROWS_A)) dut_a (
      .clock50MHz (clk),    .reset (rst_a), .start (start_a), .char_data (cd_a),
      .char_addr  (addr_a), .busy  (busy_a), .RS (rs_a), .RW (rw_a), .E (e_a), .DB (db_a)
   );

   lcd_phrase_driver #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .COLS(COLS_B), .ROWS(ROWS_B)) dut_b (
      .clock50MHz (clk),    .reset (rst_b), .start (start_b), .char_data (cd_b),
      .char_addr  (addr_b), .busy  (busy_b), .RS (rs_b), .RW (rw_b), .E (e_b), .DB (db_b)
   );

   // Phrase banks with one clock of read latency.
   always @(posedge clk) begin
      cd_a <= bank_a[addr_a];
      cd_b <= bank_b[addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: captures each write at E rise and checks strobe/setup/hold timing.
   int         stable [2] = '{0, 0};
   int         ehigh [2] = '{0, 0};
   int         hold_cnt [2] = '{0, 0};
   logic       prev_e [2] = '{1'b0, 1'b0};
   logic [8:0] prev_v [2] = '{9'h0, 9'h0};
   logic [8:0] mon_v;
   logic       mon_e, mon_rst, mon_rw, mon_busy;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mon_v    = (k == 0) ? {rs_a, db_a} : {rs_b, db_b};
         mon_e    = (k == 0) ? e_a : e_b;
         mon_rst  = (k == 0) ? rst_a : rst_b;
         mon_rw   = (k == 0) ? rw_a : rw_b;
         mon_busy = (k == 0) ? busy_a : busy_b;
         chk($sformatf("rw_low%0d", k), 32'(mon_rw), 32'd0);
         if (!mon_rst) begin
            stable[k]   = 0;
            ehigh[k]    = 0;
            hold_cnt[k] = 0;
            prev_e[k]   = 1'b0;
            prev_v[k]   = 9'h0;
         end else begin
            if (mon_v == prev_v[k]) stable[k]++;
            else stable[k] = 1;
            prev_v[k] = mon_v;
            if (mon_e && !prev_e[k]) begin
               if (k == 0) wq_a.push_back(mon_v);
               else wq_b.push_back(mon_v);
               chk($sformatf("setup_stable%0d", k), 32'(stable[k] >= D + 1), 32'd1);
            end
            if (!mon_e && prev_e[k]) begin
               chk($sformatf("strobe_len%0d", k), 32'(ehigh[k]), 32'(D));
               hold_cnt[k] = 1;
            end else if (hold_cnt[k] > 0) begin
               hold_cnt[k]++;
            end
            if (hold_cnt[k] == D) begin
               chk($sformatf("hold_stable%0d", k), 32'(stable[k] >= 3 * D), 32'd1);
               hold_cnt[k] = 0;
            end
            ehigh[k] = mon_e ? ehigh[k] + 1 : 0;
            prev_e[k] = mon_e;
            if (k == 0 && mon_busy) busy_clk_a++;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input bit a, input bit b);
      start_a = a;
      start_b = b;
      step();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_quiet(input int k, input int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 8 && n < budget) begin
         step();
         n++;
         if ((k == 0) ? busy_a : busy_b) quiet = 0;
         else quiet++;
      end
      chk($sformatf("wait_quiet%0d", k), 32'(quiet), 32'd8);
   endtask

   task automatic exp_init(input bit two_rows);
      exp_q.push_back({1'b0, two_rows ? 8'h38 : 8'h30});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
   endtask

   task automatic exp_refresh(input int k);
      int rows = (k == 0) ? ROWS_A : ROWS_B;
      int cols = (k == 0) ? COLS_A : COLS_B;
      for (int r = 0; r < rows; r++) begin
         exp_q.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
         for (int c = 0; c < cols; c++) begin
            if (k == 0) exp_q.push_back({1'b1, bank_a[r * cols + c]});
            else        exp_q.push_back({1'b1, bank_b[r * cols + c]});
         end
      end
   endtask

   task automatic check_writes(input int k, input int base, input string tag);
      int got;
      logic [8:0] w;
      got = ((k == 0) ? wq_a.size() : wq_b.size()) - base;
      chk({tag, "_count"}, 32'(got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got; i++) begin
         w = (k == 0) ? wq_a[base + i] : wq_b[base + i];
         chk($sformatf("%s_w%0d", tag, i), 32'(w), 32'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   // Counts clocks from reset release to first E high and to busy low (device A).
   task automatic measure_boot(input string tag);
      int n = 0;
      int e_at = 0;
      int busy_at = 0;
      while (n < 300 && busy_at == 0) begin
         step();
         n++;
         if (e_a && e_at == 0) e_at = n;
         if (!busy_a && busy_at == 0) busy_at = n;
      end
      chk({tag, "_first_e"}, 32'(e_at), 32'(21 * D));
      chk({tag, "_init_done"}, 32'(busy_at), 32'(33 * D));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_a, base_b, b0, blen, got;

      rst_a = 1'b0;
      rst_b = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < N_A; i++) bank_a[i] = 8'(8'h41 + i);
      for (int i = 0; i < N_B; i++) bank_b[i] = 8'(8'h41 + i);
      steps(3);

      chk("rst_busy", 32'(busy_a), 32'd1);
      chk("rst_e", 32'(e_a), 32'd0);
      chk("rst_db", 32'(db_a), 32'd0);
      chk("rst_rs", 32'(rs_a), 32'd0);
      chk("rst_rw", 32'(rw_a), 32'd0);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd1);

      // Power-up: 20-tick wait, then the four init commands.
      base_a = wq_a.size();
      base_b = wq_b.size();
      rst_a = 1'b1;
      rst_b = 1'b1;
      measure_boot("boot");
      wait_quiet(1, 100);
      exp_init(1'b1);
      check_writes(0, base_a, "init_a");
      exp_init(1'b0);
      check_writes(1, base_b, "init_b");

      // Refresh with the ascending bank.
      base_a = wq_a.size();
      base_b = wq_b.size();
      b0 = busy_clk_a;
      pulse(1'b1, 1'b1);
      chk("start_busy_a", 32'(busy_a), 32'd1);
      chk("start_busy_b", 32'(busy_b), 32'd1);
      wait_quiet(0, 600);
      wait_quiet(1, 100);
      blen = busy_clk_a - b0;
      chk("busy_len", 32'(blen >= 102 * D + 1 && blen <= 103 * D), 32'd1);
      exp_refresh(0);
      check_writes(0, base_a, "ref_a");
      exp_refresh(1);
      check_writes(1, base_b, "ref_b");

      // Random banks, random request timing, three extra requests coalescing into one.
      for (int it = 0; it < 2; it++) begin
         for (int i = 0; i < N_A; i++) bank_a[i] = 8'($urandom);
         for (int i = 0; i < N_B; i++) bank_b[i] = 8'($urandom);
         steps($urandom_range(0, 7));
         base_a = wq_a.size();
         base_b = wq_b.size();
         pulse(1'b1, 1'b1);
         for (int p = 0; p < 3; p++) begin
            steps($urandom_range(3, 40));
            pulse(1'b1, 1'b0);
         end
         wait_quiet(0, 1200);
         wait_quiet(1, 100);
         exp_refresh(0);
         exp_refresh(0);
         check_writes(0, base_a, $sformatf("coalesce%0d", it));
         exp_refresh(1);
         check_writes(1, base_b, $sformatf("single_b%0d", it));
      end

      // Reset during the fifth character of row 0.
      base_a = wq_a.size();
      pulse(1'b1, 1'b0);
      got = 0;
      for (int n = 0; n < 400 && got < 6; n++) begin
         step();
         got = wq_a.size() - base_a;
      end
      chk("reach_char5", 32'(got), 32'd6);
      rst_a = 1'b0;
      #1;
      chk("abort_e", 32'(e_a), 32'd0);
      chk("abort_db", 32'(db_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd1);
      chk("abort_rs", 32'(rs_a), 32'd0);
      chk("abort_addr", 32'(addr_a), 32'd0);
      steps(3);
      base_a = wq_a.size();
      rst_a = 1'b1;
      measure_boot("reboot");
      exp_init(1'b1);
      check_writes(0, base_a, "reinit");

      // A request during the power wait is remembered and served after init.
      rst_a = 1'b0;
      steps(2);
      base_a = wq_a.size();
      rst_a = 1'b1;
      steps(3);
      pulse(1'b1, 1'b0);
      wait_quiet(0, 1000);
      exp_init(1'b1);
      exp_refresh(0);
      check_writes(0, base_a, "early_start");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_phrase_driver.md
LCD_PHRASE_DRIVER -- requirements
Module: lcd_phrase_driver

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz, SHALL be supported.
REQ-002 Parameter TICK_HZ, default 500, LCD step rate in Hz, SHALL be supported; DIV = CLK_HZ/TICK_HZ >= 2.
REQ-003 Parameter COLS, default 16, characters per row (1..40), SHALL be supported.
REQ-004 Parameter ROWS, default 2, display rows (1 or 2), SHALL be supported; ADDR_W = clog2(ROWS*COLS).
REQ-005 Ports SHALL be:
clock50MHz  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  refresh request, single-cycle pulse or level
char_data  in  8  character code for char_addr, from the phrase bank (1-cycle latency allowed)
char_addr  out  ADDR_W  character index, row*COLS+col
busy  out  1  high during init or refresh
RS  out  1  LCD register select (0 cmd, 1 data)
RW  out  1  LCD read/write, constant 0
E  out  1  LCD enable strobe
DB  out  8  LCD data bus

Function
REQ-006 Internal tick SHALL pulse one clock every DIV clocks (counter 0..DIV-1, tick at DIV-1); all LCD steps advance only on tick.
REQ-007 Each bus write SHALL take 3 ticks: SETUP (RS/DB driven, E=0), STROBE (E=1), HOLD (E=0, RS/DB held).
REQ-008 FSM states SHALL be: PWR_WAIT, INIT, IDLE, SET_ADDR, WRITE_CHAR, CLR_WAIT.
REQ-009 PWR_WAIT SHALL last 20 ticks after reset release, then go to INIT.
REQ-010 INIT SHALL write in order: function set (0x38 if ROWS=2, 0x30 if ROWS=1), 0x0C, 0x06, 0x01; after 0x01 CLR_WAIT SHALL insert 1 idle tick, then go to IDLE.
REQ-011 In IDLE with start=1 (or pending set), the FSM SHALL go to SET_ADDR on the next clock and busy SHALL assert that clock.
REQ-012 SET_ADDR SHALL write DDRAM command 0x80 for row 0, 0xC0 for row 1; then WRITE_CHAR writes COLS data bytes (RS=1), DB = char_data sampled at SETUP tick.
REQ-013 char_addr SHALL update at least 1 clock before the SETUP tick of the character it selects.
REQ-014 After the last column of a row, the next row SHALL follow via SET_ADDR; after the last row, the FSM SHALL return to IDLE and busy SHALL deassert.
REQ-015 start while busy SHALL set a 1-bit pending flag (multiple requests coalesce); pending SHALL trigger exactly one further refresh on entering IDLE and clear then.
REQ-016 Refresh SHALL be ROWS*(COLS+1) writes = 3*ROWS*(COLS+1) ticks; default 34 writes, 102 ticks.
REQ-017 start during PWR_WAIT/INIT SHALL set pending; refresh SHALL follow init without extra request.
REQ-018 RW SHALL be 0 at all times, including reset.

Reset
REQ-019 reset=0 SHALL asynchronously force: state PWR_WAIT, tick counter 0, pending 0, busy 1, RS 0, E 0, DB 0x00, char_addr 0.
REQ-020 Reset asserted mid-refresh SHALL abort it immediately (E low same instant); after release full init SHALL rerun.

Structure
REQ-021 Package lcd_pkg SHALL hold the FSM state enum and LCD command constants (0x30, 0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0).
REQ-022 Tick generation SHALL be a sub-module lcd_tick_gen (parameter DIV, ports clock50MHz, reset, tick).

Verification (CLK_HZ=1000, TICK_HZ=500, DIV=2 unless noted)
REQ-023 Reset release, no start -> 20 ticks E=0, then 4 E pulses with DB 0x38,0x0C,0x06,0x01 (RS=0), busy falls after CLR_WAIT.
REQ-024 Bank model char=0x41+addr, start pulse in IDLE -> 0x80, 16 chars 0x41..0x50, 0xC0, 16 chars 0x51..0x60 (RS=1 for chars), busy high exactly 102 ticks.
REQ-025 Three start pulses during a refresh -> exactly two refreshes total, then busy=0.
REQ-026 ROWS=1, COLS=8 -> init first cmd 0x30; refresh 0x80 + 8 chars, no 0xC0 write.
REQ-027 reset low at character 5 of row 0 -> E=0, DB=0x00, busy=1 immediately; after release full 20-tick wait and init rerun.
REQ-028 Protocol checker throughout: E high exactly 1 tick per write, RS/DB stable from SETUP through HOLD, RW never 1.
